// File: rtl/ex_mem_stage_pkg.sv
// Shared widths, branch-type encoding and branch helpers for the EX/MEM pipeline register.
package ex_mem_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        BR_EQ = 1'b0,
        BR_NE = 1'b1
    } br_type_e;

    // beq is taken on zero, bne on non-zero; non-branches never take.
    function automatic logic branch_is_taken(input logic branch, input logic zero,
                                             input br_type_e br_type);
        return branch & (zero ^ (br_type == BR_NE));
    endfunction

    // Word offset scaled to bytes; the carry out of bit 31 is dropped.
    function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc_plus4,
                                                        input logic [DATA_W-1:0] imm_sext);
        return pc_plus4 + {imm_sext[DATA_W-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/ex_mem_stage_squash_counter.sv
// Counts the wrong-path slots still to be discarded after a taken branch.
module squash_counter
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned SHADOW = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic hold_i,
    input  logic load_i,
    input  logic dec_i,
    output logic nonzero_o
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (hold_i) begin
            count <= count;
        end else if (load_i) begin
            count <= CNT_W'(SHADOW);
        end else if (dec_i && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign nonzero_o = (count != '0);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU outputs, resolves beq/bne and squashes the branch shadow.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned SHADOW = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [REG_W-1:0]  write_reg_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] imm_sext_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              branch_i,
    input  logic              branch_ne_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [REG_W-1:0]  write_reg_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic              redirect_o,
    output logic              squashing_o
);

    logic eff_valid_c;
    logic taken_c;

    // Any arrival while the counter is non-zero is a wrong-path instruction.
    assign eff_valid_c = valid_i & ~squashing_o;
    assign taken_c     = branch_is_taken(branch_i, alu_zero_i, br_type_e'(branch_ne_i));

    squash_counter #(
        .SHADOW (SHADOW),
        .CNT_W  (CNT_W)
    ) u_squash_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (flush_i),
        .hold_i    (stall_i),
        .load_i    (eff_valid_c & taken_c),
        .dec_i     (~eff_valid_c),
        .nonzero_o (squashing_o)
    );

    // Bubbles clear every field so downstream never sees stale control or data.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || (!stall_i && !eff_valid_c)) begin
            valid_o         <= 1'b0;
            alu_result_o    <= '0;
            rt_data_o       <= '0;
            write_reg_o     <= '0;
            reg_write_o     <= 1'b0;
            mem_read_o      <= 1'b0;
            mem_write_o     <= 1'b0;
            mem_to_reg_o    <= 1'b0;
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
            redirect_o      <= 1'b0;
        end else if (stall_i) begin
            redirect_o      <= 1'b0;
        end else begin
            valid_o         <= 1'b1;
            alu_result_o    <= alu_result_i;
            rt_data_o       <= rt_data_i;
            write_reg_o     <= write_reg_i;
            reg_write_o     <= reg_write_i;
            mem_read_o      <= mem_read_i;
            mem_write_o     <= mem_write_i;
            mem_to_reg_o    <= mem_to_reg_i;
            branch_taken_o  <= taken_c;
            branch_target_o <= branch_target(pc_plus4_i, imm_sext_i);
            redirect_o      <= taken_c;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: branch resolution, shadow squash, stall, flush and reset.
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i;
    logic [31:0] alu_result_i, rt_data_i, pc_plus4_i, imm_sext_i;
    logic        alu_zero_i;
    logic [4:0]  write_reg_i;
    logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i, branch_ne_i;
    logic        valid_o;
    logic [31:0] alu_result_o, rt_data_o, branch_target_o;
    logic [4:0]  write_reg_o;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
    logic        branch_taken_o, redirect_o, squashing_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .rt_data_i(rt_data_i),
        .write_reg_i(write_reg_i), .pc_plus4_i(pc_plus4_i), .imm_sext_i(imm_sext_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i), .branch_i(branch_i), .branch_ne_i(branch_ne_i),
        .valid_o(valid_o), .alu_result_o(alu_result_o), .rt_data_o(rt_data_o),
        .write_reg_o(write_reg_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .redirect_o(redirect_o), .squashing_o(squashing_o)
    );

    task automatic idle_inputs();
        rst_i = 0; stall_i = 0; flush_i = 0; valid_i = 0;
        alu_result_i = 0; alu_zero_i = 0; rt_data_i = 0; write_reg_i = 0;
        pc_plus4_i = 0; imm_sext_i = 0;
        reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0;
        branch_i = 0; branch_ne_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_alu(input logic [31:0] res);
        idle_inputs();
        valid_i = 1; alu_result_i = res; reg_write_i = 1; write_reg_i = 5'd9;
    endtask

    task automatic drive_beq_taken();
        idle_inputs();
        valid_i = 1; branch_i = 1; alu_zero_i = 1; branch_ne_i = 0;
        pc_plus4_i = 32'h0000_0010; imm_sext_i = 32'h0000_0003;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1; valid_i = 1; alu_result_i = 32'hDEAD_BEEF; reg_write_i = 1;
        step(); step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (alu_result_o !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", alu_result_o); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", reg_write_o); end
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL reset_squash: got %b want 0", squashing_o); end
        idle_inputs();
    endtask

    task automatic test_beq_taken();
        drive_beq_taken();
        step();
        checks++; if (branch_taken_o !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", branch_taken_o); end
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %b want 1", redirect_o); end
        checks++; if (branch_target_o !== 32'h0000_001C) begin errors++; $display("FAIL beq_target: got %h want 0000001c", branch_target_o); end
        checks++; if (squashing_o !== 1'b1) begin errors++; $display("FAIL beq_squashing: got %b want 1", squashing_o); end
        drive_alu(32'h11);
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL beq_shadow1_valid: got %b want 0", valid_o); end
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL beq_shadow1_redirect: got %b want 0", redirect_o); end
        checks++; if (squashing_o !== 1'b1) begin errors++; $display("FAIL beq_shadow1_squash: got %b want 1", squashing_o); end
        drive_alu(32'h22);
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL beq_shadow2_valid: got %b want 0", valid_o); end
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL beq_shadow2_squash: got %b want 0", squashing_o); end
        drive_alu(32'h33);
        step();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL beq_third_valid: got %b want 1", valid_o); end
        checks++; if (alu_result_o !== 32'h33) begin errors++; $display("FAIL beq_third_alu: got %h want 33", alu_result_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_squash();
        drive_beq_taken();
        step();
        drive_alu(32'h44);
        rst_i = 1;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstsq_valid: got %b want 0", valid_o); end
        checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL rstsq_taken: got %b want 0", branch_taken_o); end
        checks++; if (branch_target_o !== 32'h0) begin errors++; $display("FAIL rstsq_target: got %h want 0", branch_target_o); end
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL rstsq_squash: got %b want 0", squashing_o); end
        drive_alu(32'h55);
        step();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rstsq_next_valid: got %b want 1", valid_o); end
        checks++; if (alu_result_o !== 32'h55) begin errors++; $display("FAIL rstsq_next_alu: got %h want 55", alu_result_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_bne_not_taken();
        idle_inputs();
        valid_i = 1; branch_i = 1; branch_ne_i = 1; alu_zero_i = 1;
        pc_plus4_i = 32'h0000_0004; imm_sext_i = 32'hFFFF_FFFF;
        step();
        checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL bne_taken: got %b want 0", branch_taken_o); end
        checks++; if (branch_target_o !== 32'h0) begin errors++; $display("FAIL bne_target: got %h want 0", branch_target_o); end
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL bne_redirect: got %b want 0", redirect_o); end
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL bne_squash: got %b want 0", squashing_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bne_valid: got %b want 1", valid_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_stall_taken();
        drive_beq_taken();
        step();
        checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL stall_first_redirect: got %b want 1", redirect_o); end
        drive_alu(32'h66);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL stall_redirect[%0d]: got %b want 0", i, redirect_o); end
            checks++; if (branch_taken_o !== 1'b1) begin errors++; $display("FAIL stall_taken[%0d]: got %b want 1", i, branch_taken_o); end
            checks++; if (squashing_o !== 1'b1) begin errors++; $display("FAIL stall_squash[%0d]: got %b want 1", i, squashing_o); end
        end
        stall_i = 0;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_resume1_valid: got %b want 0", valid_o); end
        checks++; if (squashing_o !== 1'b1) begin errors++; $display("FAIL stall_resume1_squash: got %b want 1", squashing_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_resume2_valid: got %b want 0", valid_o); end
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL stall_resume2_squash: got %b want 0", squashing_o); end
        step();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL stall_resume3_valid: got %b want 1", valid_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        valid_i = 1; mem_read_i = 1; mem_to_reg_i = 1; reg_write_i = 1; alu_result_i = 32'h100;
        step();
        checks++; if (mem_read_o !== 1'b1) begin errors++; $display("FAIL lw_memread: got %b want 1", mem_read_o); end
        stall_i = 1; flush_i = 1;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        checks++; if (mem_read_o !== 1'b0) begin errors++; $display("FAIL flush_memread: got %b want 0", mem_read_o); end
        checks++; if (alu_result_o !== 32'h0) begin errors++; $display("FAIL flush_alu: got %h want 0", alu_result_o); end
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL flush_squash: got %b want 0", squashing_o); end
        // Flush must also abandon a pending squash.
        drive_beq_taken();
        step();
        stall_i = 1; flush_i = 1;
        step();
        checks++; if (squashing_o !== 1'b0) begin errors++; $display("FAIL flush_sq_squash: got %b want 0", squashing_o); end
        checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL flush_sq_taken: got %b want 0", branch_taken_o); end
        drive_alu(32'h77);
        step();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL flush_sq_next_valid: got %b want 1", valid_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            res = 32'(5 + i);
            drive_alu(res);
            alu_zero_i = 1;
            step();
            checks++; if (alu_result_o !== res) begin errors++; $display("FAIL b2b_alu[%0d]: got %h want %h", i, alu_result_o, res); end
            checks++; if (reg_write_o !== 1'b1) begin errors++; $display("FAIL b2b_regwrite[%0d]: got %b want 1", i, reg_write_o); end
            checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL b2b_taken[%0d]: got %b want 0", i, branch_taken_o); end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_beq_taken();
        test_reset_mid_squash();
        test_bne_not_taken();
        test_stall_taken();
        test_flush_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register that sits directly downstream of the ALU in the 5-stage MIPS datapath.
- Captures the ALU result and zero flag together with the EX-stage control and data.
- Resolves beq/bne and computes the branch target.
- After a taken branch, squashes the wrong-path instructions that are still arriving from upstream.
- Feeds the MEM stage (data memory) and the fetch redirect logic.

Parameters:
- SHADOW, 2: number of younger instructions already in flight behind a taken branch; each is squashed on arrival.
- CNT_W, 2: width of the squash counter; must satisfy 2^CNT_W > SHADOW.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hold stage contents and squash counter
- flush_i  in  1  discard stage contents and pending squash (exception/external redirect)
- valid_i  in  1  incoming EX-stage instruction is real
- alu_result_i  in  32  ALU result_o
- alu_zero_i  in  1  ALU zero_o
- rt_data_i  in  32  store data
- write_reg_i  in  5  destination register number
- pc_plus4_i  in  32  PC+4 of the EX instruction
- imm_sext_i  in  32  sign-extended 16-bit immediate
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i  in  1 each  control bits
- branch_ne_i  in  1  0 = beq, 1 = bne
- valid_o  out  1  stage holds a real instruction
- alu_result_o, rt_data_o  out  32  registered copies
- write_reg_o  out  5  registered copy
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1  registered; forced 0 when valid_o=0
- branch_taken_o  out  1  held instruction is a taken branch
- branch_target_o  out  32  pc_plus4 + (imm_sext << 2), modulo 2^32
- redirect_o  out  1  one-cycle pulse in the first cycle a taken branch appears at the outputs
- squashing_o  out  1  squash counter non-zero

Behaviour:
- Reset: when rst_i=1 at an edge, all outputs and the squash counter go to 0. Reset has highest priority and may interrupt a squash sequence or stall.
- Update priority at each edge: rst_i > flush_i > stall_i > load.
- flush_i: load a bubble (all outputs 0) and clear the counter.
- stall_i: all registers and the counter hold. redirect_o is forced to 0 in held cycles, so it is never repeated.
- Load, eff_valid: eff_valid = valid_i AND (counter == 0).
  - If eff_valid=0: load a bubble (all outputs 0). If counter > 0, decrement it by 1.
  - If eff_valid=1: register all data and control inputs.
    - taken = branch_i AND (alu_zero_i XOR branch_ne_i).
    - branch_taken_o <= taken; redirect_o <= taken.
    - branch_target_o <= pc_plus4_i + {imm_sext_i[29:0], 2'b00}; the carry is dropped.
    - If taken, counter <= SHADOW.
- Latency: 1 cycle from input to output. There are no combinational paths from inputs to outputs.
- A taken branch cannot be loaded while counter > 0, because all arrivals are squashed.
- Non-branch instruction with alu_zero_i=1: branch_taken_o=0.
- Boundaries:
  - valid_i=0 during a squash still decrements the counter; a bubble counts as a shadow slot.
  - stall_i and flush_i both asserted: flush_i wins.
  - SHADOW=0: no squashing occurs.

Decomposition:
- Shared package holds:
  - datapath width constant (32)
  - register-index width (5)
  - branch-type encoding (BR_EQ=0, BR_NE=1)
- The squash counter is a natural sub-module: squash_counter. It has load, decrement, hold and clear inputs and a nonzero output.
- Target adder and pipeline registers stay inline.

Test Plan:
- Reset mid-squash: load a taken beq, then assert rst_i on the next edge. Required: all outputs 0, squashing_o=0, next valid_i=1 is loaded normally.
- beq taken: alu_zero_i=1, branch_i=1, branch_ne_i=0, pc_plus4_i=0x0000_0010, imm_sext_i=0x0000_0003. Required next cycle: branch_taken_o=1, redirect_o=1, branch_target_o=0x0000_001C, squashing_o=1. The following 2 valid_i=1 inputs produce valid_o=0; the third is loaded with valid_o=1.
- bne not taken with a negative offset: alu_zero_i=1, branch_ne_i=1, imm_sext_i=0xFFFF_FFFF, pc_plus4_i=0x0000_0004. Required: branch_taken_o=0, branch_target_o=0x0000_0000, no squash.
- Stall while holding a taken branch: after load, hold stall_i=1 for 3 cycles. Required: redirect_o is 1 for the first cycle only, branch_taken_o stays 1, the counter stays at 2, and squashing resumes once stall_i=0.
- flush_i together with stall_i while holding lw (mem_read_i=1, alu_result_i=0x100). Required: valid_o=0, mem_read_o=0, alu_result_o=0, squashing_o=0.
- Back-to-back ALU ops (results 5, 6, 7) with no stall. Required: alu_result_o equals 5, 6, 7 on consecutive cycles, reg_write_o=1 throughout.
